// File: rtl/tbec_ecc_mem_ctrl.sv
// SECDED-protected single-port memory controller: valid/ready requests, registered read, correct-on-read
// write-back, power-up init sweep, saturating error counters. Background scrubber enabled by TBEC_SCRUB_EN.
module tbec_ecc_mem_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int ERR_CNT_W      = 8,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W-1:0]    inj_mask,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic [ERR_CNT_W-1:0] ce_count,
    output logic [ERR_CNT_W-1:0] ue_count,
    output logic                 init_busy,
    output logic                 scrub_busy,
    output logic [2:0]           dbg_state
);
    function automatic int calc_chk_w(input int dw);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    localparam int CHK_W = calc_chk_w(DATA_W);
    localparam int CW    = DATA_W + CHK_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CE   = 2'b01;
    localparam logic [1:0] ERR_UE   = 2'b10;

    if (SCRUB_INTERVAL < 1) begin : g_bad_interval
        $error("SCRUB_INTERVAL must be at least 1");
    end

    // Hamming position of data bit j: the j-th position (from 3) that is not a power of two.
    function automatic logic [CHK_W-1:0] hpos(input int j);
        int cnt;
        hpos = '0;
        cnt  = 0;
        for (int p = 3; p < (1 << CHK_W); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) hpos = CHK_W'(p);
                cnt = cnt + 1;
            end
        end
    endfunction

    function automatic logic [CHK_W-1:0] ham_p(input logic [DATA_W-1:0] d);
        ham_p = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (d[j]) ham_p = ham_p ^ hpos(j);
        end
    endfunction

    // Codeword layout: {overall parity, hamming check bits, data}.
    function automatic logic [CHK_W:0] enc_chk(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] p;
        p = ham_p(d);
        return {^{d, p}, p};
    endfunction

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_RD_ARR, ST_RD_DEC, ST_RD_WB, ST_SCR_ARR, ST_SCR_DEC, ST_SCR_WB
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    init_ptr_q, init_ptr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CW-1:0]        arr_q;
    logic [CW-1:0]        wb_q;
    logic [ERR_CNT_W-1:0] ce_count_q, ue_count_q;
    logic [CW-1:0]        mem_q [DEPTH];

    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [CW-1:0]        mem_wdata;
    logic                 scrub_start;
    logic                 in_arr, in_dec;

    logic [DATA_W-1:0]    arr_data;
    logic [CHK_W-1:0]     syn;
    logic                 arr_odd;
    logic [DATA_W-1:0]    fix;
    logic [1:0]           dec_err;
    logic [DATA_W-1:0]    dec_data;
    logic [CW-1:0]        wb_d;

    assign in_arr = (state_q == ST_RD_ARR) || (state_q == ST_SCR_ARR);
    assign in_dec = (state_q == ST_RD_DEC) || (state_q == ST_SCR_DEC);

    // Decode: odd overall parity with a syndrome that names a real position is correctable.
    always_comb begin
        arr_data = arr_q[DATA_W-1:0];
        syn      = arr_q[DATA_W +: CHK_W] ^ ham_p(arr_data);
        arr_odd  = ^arr_q;
        fix      = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (syn == hpos(j)) fix[j] = 1'b1;
        end
        if (!arr_odd) begin
            dec_err = (syn == '0) ? ERR_NONE : ERR_UE;
        end else if (((syn & (syn - 1'b1)) == '0) || (fix != '0)) begin
            dec_err = ERR_CE;
        end else begin
            dec_err = ERR_UE;
        end
        dec_data = (dec_err == ERR_CE) ? (arr_data ^ fix) : arr_data;
        wb_d     = {enc_chk(dec_data), dec_data};
    end

`ifdef TBEC_SCRUB_EN
    localparam int SCNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [SCNT_W-1:0] scrub_cnt_q;
    logic              scrub_pending_q;
    logic [ADDR_W-1:0] scrub_ptr_q;
    logic              scrub_tick;

    assign scrub_tick = (state_q != ST_INIT) && (scrub_cnt_q == SCNT_W'(SCRUB_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scrub_cnt_q     <= '0;
            scrub_pending_q <= 1'b0;
            scrub_ptr_q     <= '0;
        end else begin
            if (state_q != ST_INIT) begin
                scrub_cnt_q <= scrub_tick ? '0 : scrub_cnt_q + 1'b1;
            end
            scrub_pending_q <= scrub_tick || (scrub_pending_q && !scrub_start);
            if (state_q == ST_SCR_DEC) scrub_ptr_q <= scrub_ptr_q + 1'b1;
        end
    end

    assign scrub_busy = (state_q == ST_SCR_ARR) || (state_q == ST_SCR_DEC) || (state_q == ST_SCR_WB);
`else
    assign scrub_busy = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        addr_d      = addr_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = wb_q;
        req_ready   = 1'b0;
        scrub_start = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_ptr_q;
                mem_wdata  = '0;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
`ifdef TBEC_SCRUB_EN
                scrub_start = scrub_pending_q && !req_valid;
                if (scrub_start) begin
                    addr_d  = scrub_ptr_q;
                    state_d = ST_SCR_ARR;
                end
`endif
                req_ready = !scrub_start;
                if (req_valid && req_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = req_addr;
                    mem_wdata = {enc_chk(req_wdata), req_wdata ^ inj_mask};
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = ST_RD_ARR;
                end
            end
            ST_RD_ARR: state_d = ST_RD_DEC;
            ST_RD_DEC: state_d = (dec_err == ERR_CE) ? ST_RD_WB : ST_IDLE;
            ST_RD_WB: begin
                mem_we  = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef TBEC_SCRUB_EN
            ST_SCR_ARR: state_d = ST_SCR_DEC;
            ST_SCR_DEC: state_d = (dec_err == ERR_CE) ? ST_SCR_WB : ST_IDLE;
            ST_SCR_WB: begin
                mem_we  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            ce_count_q <= '0;
            ue_count_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            if (in_dec && (dec_err == ERR_CE) && (ce_count_q != '1)) ce_count_q <= ce_count_q + 1'b1;
            if (in_dec && (dec_err == ERR_UE) && (ue_count_q != '1)) ue_count_q <= ue_count_q + 1'b1;
        end
    end

    // Storage and read pipeline carry no reset; contents are established by the init sweep.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        addr_q <= addr_d;
        if (in_arr) arr_q <= mem_q[addr_q];
        if (in_dec) wb_q <= wb_d;
    end

    assign rsp_valid = (state_q == ST_RD_DEC);
    assign rsp_rdata = rsp_valid ? dec_data : '0;
    assign rsp_err   = rsp_valid ? dec_err : ERR_NONE;
    assign ce_count  = ce_count_q;
    assign ue_count  = ue_count_q;
    assign init_busy = (state_q == ST_INIT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tbec_ecc_mem_ctrl.sv
// Bench for tbec_ecc_mem_ctrl: directed steps plus randomized traffic against a word-level error model.
module tb_tbec_ecc_mem_ctrl;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int CNT_MAX = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] inj_mask = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_err;
    logic [7:0]    ce_count;
    logic [7:0]    ue_count;
    logic          init_busy;
    logic          scrub_busy;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    tbec_ecc_mem_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .ERR_CNT_W(8), .SCRUB_INTERVAL(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .inj_mask(inj_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ce_count(ce_count), .ue_count(ue_count),
        .init_busy(init_busy), .scrub_busy(scrub_busy), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: true value, stored raw value and number of flipped data bits per word.
    logic [DW-1:0] m_true [256];
    logic [DW-1:0] m_raw  [256];
    int            m_nerr [256];
    int            exp_ce;
    int            exp_ue;
    logic [DW-1:0] exp_q [$];
    logic [1:0]    exp_err_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : CNT_MAX;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_true[i] = '0;
            m_raw[i]  = '0;
            m_nerr[i] = 0;
        end
        exp_ce = 0;
        exp_ue = 0;
    endtask

    // Present a request from a falling edge; returns #1 after the accepting rising edge.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] mask, output bit ok);
        int waited;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        inj_mask  = mask;
        waited    = 0;
        while (!req_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        ok = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        inj_mask  = '0;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic [DW-1:0] mask,
                      input string tag);
        bit ok;
        m_true[addr] = wd;
        m_raw[addr]  = wd ^ mask;
        m_nerr[addr] = $countones(mask);
        send(1'b1, addr, wd, mask, ok);
        chk({tag, "_wr_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic rd_check(input logic [AW-1:0] addr, input string tag);
        bit            ok;
        int            lat;
        logic [DW-1:0] e_d;
        logic [1:0]    e_e;
        if (m_nerr[addr] == 0) begin
            exp_q.push_back(m_true[addr]);
            exp_err_q.push_back(2'b00);
        end else if (m_nerr[addr] == 1) begin
            exp_q.push_back(m_true[addr]);
            exp_err_q.push_back(2'b01);
            exp_ce       = sat_inc(exp_ce);
            m_nerr[addr] = 0;
            m_raw[addr]  = m_true[addr];
        end else begin
            exp_q.push_back(m_raw[addr]);
            exp_err_q.push_back(2'b10);
            exp_ue = sat_inc(exp_ue);
        end
        send(1'b0, addr, '0, '0, ok);
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        chk({tag, "_rdy_arr"}, 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 1);
        e_d = exp_q.pop_front();
        e_e = exp_err_q.pop_front();
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(e_d));
        chk({tag, "_err"}, 32'(rsp_err), 32'(e_e));
        chk({tag, "_rdy_dec"}, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
`ifndef TBEC_SCRUB_EN
        chk({tag, "_rdy_after"}, 32'(req_ready), (e_e == 2'b01) ? 32'd0 : 32'd1);
`endif
        if (e_e == 2'b01) begin
            @(posedge clk);
            #1;
`ifndef TBEC_SCRUB_EN
            chk({tag, "_rdy_after_wb"}, 32'(req_ready), 32'd1);
`endif
        end
        chk({tag, "_ce"}, 32'(ce_count), 32'(exp_ce));
        chk({tag, "_ue"}, 32'(ue_count), 32'(exp_ue));
    endtask

    // Release reset and measure the init sweep; returns when init_busy drops or the budget expires.
    task automatic release_and_init(input string tag);
        int n;
        bit rdy_seen;
        bit rsp_seen;
        @(negedge clk);
        rst_n    = 1'b1;
        n        = 0;
        rdy_seen = 0;
        rsp_seen = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (init_busy && req_ready) rdy_seen = 1;
            if (rsp_valid) rsp_seen = 1;
        end while (init_busy && n < 400);
        chk({tag, "_init_len"}, n, 256);
        chk({tag, "_rdy_in_init"}, 32'(rdy_seen), 32'd0);
        chk({tag, "_rsp_in_init"}, 32'(rsp_seen), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit            ok;
        bit            rsp_seen;
        int            nb;
        int            b1;
        int            b2;
        logic [DW-1:0] mask;
        logic [AW-1:0] a;

        // Step 1: reset values, init sweep length, read of a swept word.
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_ce", 32'(ce_count), 32'd0);
        chk("rst_ue", 32'(ue_count), 32'd0);
        chk("rst_init_busy", 32'(init_busy), 32'd1);
        chk("rst_scrub_busy", 32'(scrub_busy), 32'd0);
        release_and_init("t1");
        rd_check(8'h00, "t1_rd0");

`ifdef TBEC_SCRUB_EN
        // Step 5: a single-bit error is found and repaired by the background scrubber.
        wr(8'h04, 16'hE1F0, 16'h8000, "t5");
        rsp_seen = 0;
        for (int i = 0; i < 256 * 16 + 16; i++) begin
            @(posedge clk);
            #1;
            if (scrub_busy) rsp_seen = 1;
            if (rsp_valid) chk("t5_no_rsp_on_scrub", 32'(rsp_valid), 32'd0);
        end
        exp_ce    = sat_inc(exp_ce);
        m_nerr[4] = 0;
        m_raw[4]  = m_true[4];
        chk("t5_scrub_seen", 32'(rsp_seen), 32'd1);
        chk("t5_ce_after_scrub", 32'(ce_count), 32'd1);
        rd_check(8'h04, "t5_rd");
`else
        // Steps 2-4: clean, single-bit and double-bit words.
        wr(8'h01, 16'hE1F0, 16'h0000, "t2");
        rd_check(8'h01, "t2_rd");
        wr(8'h02, 16'hE1F0, 16'h0001, "t3");
        rd_check(8'h02, "t3_rd");
        chk("t3_ce_one", 32'(ce_count), 32'd1);
        rd_check(8'h02, "t3_rerd");
        wr(8'h03, 16'hE1F0, 16'h0003, "t4");
        rd_check(8'h03, "t4_rd");
        chk("t4_ue_one", 32'(ue_count), 32'd1);
        rd_check(8'h03, "t4_rerd");
        chk("t4_ue_two", 32'(ue_count), 32'd2);

        // Randomized traffic over a small address window so reads hit written words.
        for (int i = 0; i < 150; i++) begin
            a = 8'(8'h10 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                nb   = $urandom_range(0, 2);
                b1   = $urandom_range(0, 15);
                b2   = (b1 + $urandom_range(1, 15)) % 16;
                mask = '0;
                if (nb >= 1) mask[b1] = 1'b1;
                if (nb == 2) mask[b2] = 1'b1;
                wr(a, 16'($urandom), mask, "rnd");
            end else begin
                rd_check(a, "rnd_rd");
            end
        end

        // Uncorrectable counter saturates at its maximum.
        wr(8'h05, 16'h1234, 16'h0810, "sat");
        for (int i = 0; i < 260; i++) rd_check(8'h05, "sat_rd");
        chk("sat_ue_max", 32'(ue_count), 32'(CNT_MAX));
`endif

        // Step 6: reset during RD_ARR abandons the read and clears counters.
        send(1'b0, 8'h01, '0, '0, ok);
        chk("t6_accept", 32'(ok), 32'd1);
        rst_n    = 1'b0;
        rsp_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rsp_seen = 1;
        end
        chk("t6_rsp_in_reset", 32'(rsp_seen), 32'd0);
        chk("t6_ce", 32'(ce_count), 32'd0);
        chk("t6_ue", 32'(ue_count), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd0);
        chk("t6_init_busy", 32'(init_busy), 32'd1);
        model_reset();
        release_and_init("t6");
        rd_check(8'h01, "t6_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
